// File: rtl/multicycle_controller.sv
// Main control FSM and ALU decoder for the multicycle RV32I core.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky HALT state.
module multicycle_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic [2:0]           ALUControl,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal_op
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       mem_req_c, pc_write_c, mem_write_c, ir_write_c, reg_write_c;
  logic       retire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next  = state;
    mem_req_c   = 1'b0;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    unique case (state)
      FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // Branch target (OldPC + imm) is precomputed here while the opcode is decoded.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      state_next = HALT;
`else
          default:      state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      MEMWRITE: begin
        mem_req_c   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        state_next  = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        pc_write_c = Zero;
        state_next = FETCH;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_next = ALUWB;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // jal retires once, through its ALUWB step.
  assign retire = (state_next == FETCH) &&
                  (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ);

  always_comb begin
    ALUControl = 3'b000;
    unique case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Enables are masked while reset is held so nothing is written mid-reset.
  assign mem_req  = mem_req_c   & ~reset;
  assign PCWrite  = pc_write_c  & ~reset;
  assign MemWrite = mem_write_c & ~reset;
  assign IRWrite  = ir_write_c  & ~reset;
  assign RegWrite = reg_write_c & ~reset;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_op = (state == HALT);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected control traces built from the ISA step tables.
module tb_multicycle_controller;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          funct7b5, Zero, mem_ready;
  logic          mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]    ALUControl;
  logic [IW-1:0] instret;
  logic          illegal_op;

  always #5 clk = ~clk;

  multicycle_controller #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .instret(instret), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       mem_req, pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic       reg_write;
    logic [2:0] alu_control;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    logic ready;
    logic zero;
  } ent_t;

  typedef enum {C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL, C_BAD} cls_t;

  int checks  = 0;
  int errors  = 0;
  int retired = 0;

  function automatic ctl_t sample();
    ctl_t s;
    s.mem_req     = mem_req;
    s.pc_write    = PCWrite;
    s.adr_src     = AdrSrc;
    s.mem_write   = MemWrite;
    s.ir_write    = IRWrite;
    s.result_src  = ResultSrc;
    s.alu_src_a   = ALUSrcA;
    s.alu_src_b   = ALUSrcB;
    s.imm_src     = ImmSrc;
    s.reg_write   = RegWrite;
    s.alu_control = ALUControl;
    return s;
  endfunction

  function automatic logic [6:0] opcode(cls_t c);
    case (c)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BEQ:   return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(cls_t c);
    case (c)
      C_SW:    return 2'b01;
      C_BEQ:   return 2'b10;
      C_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ISA meaning of the arithmetic instruction: only register-register funct3=000 can subtract.
  function automatic logic [2:0] alu_of(cls_t c, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (c == C_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rz();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    check_vec({tag, " enables"}, 32'({PCWrite, IRWrite, MemWrite, RegWrite, mem_req}), 32'd0);
    check_vec({tag, " instret"}, 32'(instret), 32'd0);
    check_vec({tag, " illegal"}, 32'(illegal_op), 32'd0);
  endtask

  task automatic cycle(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input ent_t e, input string tag, input logic exp_ill);
    @(negedge clk);
    op = o; funct3 = f3; funct7b5 = f7; mem_ready = e.ready; Zero = e.zero;
    #1;
    check_vec({tag, " ctl"}, 32'(sample()), 32'(e.exp));
    check_vec({tag, " instret"}, 32'(instret), 32'(retired % (1 << IW)));
    check_vec({tag, " illegal"}, 32'(illegal_op), 32'(exp_ill));
  endtask

  // z: 0/1 forces the branch Zero flag, 2 randomizes it. abort_at >= 0 asserts reset at that step.
  task automatic run_instr(input cls_t c, input logic [2:0] f3, input logic f7, input int fw,
                           input int mw, input int z, input int abort_at, input string tag);
    ent_t q[$];
    ctl_t b, x;
    logic zv;
    logic [6:0] o;
    o = opcode(c);
    b = '0;
    b.imm_src = imm_of(c);
    for (int i = 0; i <= fw; i++) begin
      x = b; x.mem_req = 1'b1; x.alu_src_b = 2'b10; x.result_src = 2'b10;
      x.ir_write = (i == fw); x.pc_write = (i == fw);
      q.push_back('{x, (i == fw), rz()});
    end
    x = b; x.alu_src_a = 2'b01; x.alu_src_b = 2'b01;
    q.push_back('{x, rz(), rz()});
    case (c)
      C_LW, C_SW: begin
        x = b; x.alu_src_a = 2'b10; x.alu_src_b = 2'b01;
        q.push_back('{x, rz(), rz()});
        for (int i = 0; i <= mw; i++) begin
          x = b; x.mem_req = 1'b1; x.adr_src = 1'b1; x.mem_write = (c == C_SW);
          q.push_back('{x, (i == mw), rz()});
        end
        if (c == C_LW) begin
          x = b; x.result_src = 2'b01; x.reg_write = 1'b1;
          q.push_back('{x, rz(), rz()});
        end
      end
      C_R, C_I: begin
        x = b; x.alu_src_a = 2'b10; x.alu_src_b = (c == C_R) ? 2'b00 : 2'b01;
        x.alu_control = alu_of(c, f3, f7);
        q.push_back('{x, rz(), rz()});
        x = b; x.reg_write = 1'b1;
        q.push_back('{x, rz(), rz()});
      end
      C_BEQ: begin
        zv = (z == 2) ? rz() : 1'(z);
        x = b; x.alu_src_a = 2'b10; x.alu_control = 3'b001; x.pc_write = zv;
        q.push_back('{x, rz(), zv});
      end
      C_JAL: begin
        x = b; x.alu_src_a = 2'b01; x.alu_src_b = 2'b10; x.pc_write = 1'b1;
        q.push_back('{x, rz(), rz()});
        x = b; x.reg_write = 1'b1;
        q.push_back('{x, rz(), rz()});
      end
      default: ;
    endcase
    foreach (q[i]) begin
      cycle(o, f3, f7, q[i], $sformatf("%s[%0d]", tag, i), 1'b0);
      if (i == abort_at) begin
        #1 reset = 1'b1;
        #1 reset_check({tag, " abort"});
        retired = 0;
        return;
      end
    end
    if (c != C_BAD) retired++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    cls_t c;
    logic [2:0] f3;
    logic [2:0] f3_tab [4];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b010; f3_tab[2] = 3'b110; f3_tab[3] = 3'b111;
    reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    @(negedge clk); #1 reset_check("por");
    @(negedge clk); mem_ready = 1'b1; #1 reset_check("por_ready");
    release_reset();

    run_instr(C_R,   3'b000, 1'b0, 0, 0, 2, -1, "add");
    run_instr(C_R,   3'b000, 1'b1, 1, 0, 2, -1, "sub");
    run_instr(C_R,   3'b010, 1'b0, 0, 0, 2, -1, "slt");
    run_instr(C_I,   3'b000, 1'b1, 0, 0, 2, -1, "addi_f7");
    run_instr(C_LW,  3'b010, 1'b0, 0, 3, 2, -1, "lw_wait3");
    run_instr(C_SW,  3'b010, 1'b0, 2, 2, 2, -1, "sw_wait2");
    run_instr(C_BEQ, 3'b000, 1'b0, 0, 0, 1, -1, "beq_taken");
    run_instr(C_BEQ, 3'b000, 1'b0, 0, 0, 0, -1, "beq_not");
    run_instr(C_JAL, 3'b000, 1'b0, 0, 0, 2, -1, "jal");
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    run_instr(C_BAD, 3'b000, 1'b0, 0, 0, 2, -1, "bad_skip");
    run_instr(C_I,   3'b111, 1'b0, 0, 0, 2, -1, "andi_after_bad");
`endif

    for (int n = 0; n < 40; n++) begin
      c  = cls_t'($urandom_range(0, 5));
      f3 = ($urandom_range(0, 4) == 4) ? 3'($urandom) : f3_tab[$urandom_range(0, 3)];
      run_instr(c, f3, rz(), $urandom_range(0, 2), $urandom_range(0, 2), 2, -1,
                $sformatf("rnd%0d", n));
    end

    run_instr(C_LW, 3'b010, 1'b0, 0, 3, 2, 3, "lw_abort");
    release_reset();
    run_instr(C_R, 3'b111, 1'b0, 0, 0, 2, -1, "and_after_reset");

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    begin
      ent_t h;
      run_instr(C_BAD, 3'b000, 1'b0, 0, 0, 2, -1, "bad_trap");
      for (int n = 0; n < 10; n++) begin
        h.exp = '0; h.ready = rz(); h.zero = rz();
        cycle(7'b1111111, 3'b000, 1'b0, h, $sformatf("halt%0d", n), 1'b1);
      end
      @(negedge clk); reset = 1'b1; #1 reset_check("halt_reset");
      retired = 0;
      release_reset();
      run_instr(C_R, 3'b000, 1'b1, 0, 0, 2, -1, "sub_after_halt");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
